// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: FSM states,
// operation encoding and default memory geometry.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERR    = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam int DMEM_BASE_ADDR = 1024;
    localparam int DMEM_SIZE      = 64;

    // The counter runs WAIT_CYCLES-1 down to 0, one ACCESS cycle per value.
    function automatic logic [3:0] wait_load(input int wait_cycles);
        return 4'(wait_cycles - 1);
    endfunction

endpackage

// File: rtl/dmem_addr_check.sv
// Translates a byte address into a data-memory word index and flags
// addresses that are below the base, misaligned or past the last word.
module dmem_addr_check
    import mem_ctrl_pkg::*;
#(
    parameter int LEN       = 32,
    parameter int MEM_SIZE  = DMEM_SIZE,
    parameter int BASE_ADDR = DMEM_BASE_ADDR
) (
    input  logic [LEN-1:0] Add,
    output logic [LEN-1:0] word,
    output logic           valid
);

    localparam logic [LEN-1:0] BASE = LEN'(BASE_ADDR);
    localparam logic [LEN-1:0] SIZE = LEN'(MEM_SIZE);

    logic [LEN-1:0] offset;

    // NOTE: every output gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        offset = Add - BASE;
        word   = offset >> 2;
        valid  = (Add >= BASE) && (Add[1:0] == 2'b00) && (word < SIZE);
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle controller between the MEM stage and a single-port data memory;
// holds strobes for WAIT_CYCLES and stalls the pipeline through `ready`.
module data_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int LEN         = 32,
    parameter int MEM_SIZE    = DMEM_SIZE,
    parameter int BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int WAIT_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           MEM_read,
    input  logic           MEM_write,
    input  logic [LEN-1:0] Add,
    input  logic [LEN-1:0] input_data,
    output logic [LEN-1:0] out_data,
    output logic           ready,
    output logic           addr_error,
    output logic [LEN-1:0] mem_addr,
    output logic [LEN-1:0] mem_wdata,
    output logic           mem_we,
    output logic           mem_re,
    input  logic [LEN-1:0] mem_rdata
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 1..15");
    end

    localparam logic [3:0] COUNT_LOAD = wait_load(WAIT_CYCLES);

    state_t         state;
    op_t            op;
    logic [3:0]     count;
    logic           req;
    logic [LEN-1:0] word;
    logic           addr_ok;

    assign req = MEM_read | MEM_write;

    dmem_addr_check #(
        .LEN      (LEN),
        .MEM_SIZE (MEM_SIZE),
        .BASE_ADDR(BASE_ADDR)
    ) u_addr_check (
        .Add  (Add),
        .word (word),
        .valid(addr_ok)
    );

    // Low in the request cycle itself so the stall begins without a bubble.
    assign ready = ((state == IDLE) && !req) || (state == DONE);

    // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op         <= OP_RD;
            count      <= '0;
            out_data   <= '0;
            addr_error <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    addr_error <= 1'b0;
                    if (req) begin
                        if (addr_ok) begin
                            // A simultaneous read+write is treated as a write.
                            op        <= MEM_write ? OP_WR : OP_RD;
                            mem_addr  <= word;
                            mem_wdata <= input_data;
                            count     <= COUNT_LOAD;
                            mem_re    <= !MEM_write;
                            mem_we    <= MEM_write && (WAIT_CYCLES == 1);
                            state     <= ACCESS;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                ACCESS: begin
                    if (count == 4'd0) begin
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        if (op == OP_RD) begin
                            out_data <= mem_rdata;
                        end
                        state <= DONE;
                    end else begin
                        count  <= count - 4'd1;
                        // Raise the write strobe only for the final cycle: one write edge.
                        mem_we <= (op == OP_WR) && (count == 4'd1);
                    end
                end
                ERR: begin
                    out_data   <= '0;
                    addr_error <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    addr_error <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: stimulus queues expected completions,
// a negedge monitor pops and compares them when ready returns high.
module tb_data_mem_ctrl;

    typedef struct {
        logic        err;
        logic [31:0] data;
        logic [31:0] word;
        logic [31:0] wdata;
        int          we_n;
        int          we_pos;
        int          re_n;
        int          lo_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MEM_read, MEM_write;
    logic [31:0] Add, input_data;
    logic [31:0] out_data, mem_addr, mem_wdata, mem_rdata;
    logic        ready, addr_error, mem_we, mem_re;

    // NOTE: the memory array has no reset; only the controller's state is reset.
    logic [31:0] mem [64];

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   we_total = 0;

    data_mem_ctrl #(
        .LEN(32), .MEM_SIZE(64), .BASE_ADDR(1024), .WAIT_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .MEM_read(MEM_read), .MEM_write(MEM_write),
        .Add(Add), .input_data(input_data),
        .out_data(out_data), .ready(ready), .addr_error(addr_error),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:0]];
    always @(posedge clk) if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic exp_t exp_wr(input logic [31:0] w, input logic [31:0] d, input logic [31:0] keep);
        exp_t e;
        e = '{err: 1'b0, data: keep, word: w, wdata: d, we_n: 1, we_pos: 5, re_n: 0, lo_n: 5};
        return e;
    endfunction

    function automatic exp_t exp_rd(input logic [31:0] w, input logic [31:0] d);
        exp_t e;
        e = '{err: 1'b0, data: d, word: w, wdata: 32'h0, we_n: 0, we_pos: 0, re_n: 4, lo_n: 5};
        return e;
    endfunction

    function automatic exp_t exp_err();
        exp_t e;
        e = '{err: 1'b1, data: 32'h0, word: 32'h0, wdata: 32'h0, we_n: 0, we_pos: 0, re_n: 0, lo_n: 2};
        return e;
    endfunction

    // Monitor: accumulates strobe activity while ready is low, compares on completion.
    int          lo_n = 0, we_n = 0, re_n = 0, we_pos = 0;
    logic        prev_ready = 1'b1;
    logic [31:0] cap_addr = '0, cap_wdata = '0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            lo_n = 0; we_n = 0; re_n = 0; we_pos = 0;
            prev_ready = 1'b1;
        end else begin
            if (mem_we) begin
                we_n++; we_total++;
                we_pos = lo_n + 1;
                cap_addr = mem_addr; cap_wdata = mem_wdata;
            end
            if (mem_re) begin
                re_n++;
                cap_addr = mem_addr;
            end
            if (!ready) begin
                lo_n++;
            end else if (!prev_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("addr_error", 32'(addr_error), 32'(e.err));
                    check("out_data", out_data, e.data);
                    check("we_cycles", 32'(we_n), 32'(e.we_n));
                    check("re_cycles", 32'(re_n), 32'(e.re_n));
                    check("stall_cycles", 32'(lo_n), 32'(e.lo_n));
                    if (!e.err) check("mem_addr", cap_addr, e.word);
                    if (e.we_n > 0) begin
                        check("mem_wdata", cap_wdata, e.wdata);
                        check("we_position", 32'(we_pos), 32'(e.we_pos));
                    end
                end
                lo_n = 0; we_n = 0; re_n = 0; we_pos = 0;
                done_cnt++;
                done_cyc = cyc;
            end else if (addr_error) begin
                check("stray_addr_error", 32'(addr_error), 32'd0);
            end
            prev_ready = ready;
        end
    end

    task automatic wait_done();
        int target;
        bit ok;
        target = done_cnt + 1;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) ok = 1;
        end
        if (!ok) check("completion_timeout", 32'(done_cnt), 32'(target));
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        MEM_read = rd; MEM_write = wr; Add = a; input_data = d;
        wait_done();
        MEM_read = 1'b0; MEM_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_before;
        int t_prev;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst_n = 1'b0; MEM_read = 1'b0; MEM_write = 1'b0; Add = '0; input_data = '0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready", 32'(ready), 32'd1);
        check("idle_addr_error", 32'(addr_error), 32'd0);

        // Write then read back
        do_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, exp_wr(32'd2, 32'hDEADBEEF, 32'h0));
        do_access(1'b1, 1'b0, 32'd1032, 32'h0, exp_rd(32'd2, 32'hDEADBEEF));

        // Address errors: below base, misaligned, one past the last word
        do_access(1'b1, 1'b0, 32'd1020, 32'h0, exp_err());
        do_access(1'b0, 1'b1, 32'd1030, 32'h1, exp_err());
        do_access(1'b1, 1'b0, 32'd1280, 32'h0, exp_err());

        // Last valid word
        do_access(1'b0, 1'b1, 32'd1276, 32'hA5A50063, exp_wr(32'd63, 32'hA5A50063, 32'h0));
        do_access(1'b1, 1'b0, 32'd1276, 32'h0, exp_rd(32'd63, 32'hA5A50063));

        // Simultaneous read+write behaves as a write and keeps out_data
        do_access(1'b1, 1'b1, 32'd1028, 32'd5, exp_wr(32'd1, 32'd5, 32'hA5A50063));
        do_access(1'b1, 1'b0, 32'd1028, 32'h0, exp_rd(32'd1, 32'd5));

        // Reset in the second ACCESS cycle of a write
        we_before = we_total;
        @(posedge clk);
        #1;
        MEM_write = 1'b1; Add = 32'd1036; input_data = 32'd7;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0; MEM_write = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_mem_re", 32'(mem_re), 32'd0);
        check("abort_out_data", out_data, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_write", 32'(we_total), 32'(we_before));
        do_access(1'b1, 1'b0, 32'd1036, 32'h0, exp_rd(32'd3, 32'h0));

        // Held read request: one access per IDLE..DONE, ready every 6 cycles
        do_access(1'b0, 1'b1, 32'd1024, 32'h12345678, exp_wr(32'd0, 32'h12345678, 32'h0));
        for (int k = 0; k < 3; k++) exp_q.push_back(exp_rd(32'd0, 32'h12345678));
        @(posedge clk);
        #1;
        MEM_read = 1'b1; Add = 32'd1024;
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            wait_done();
            if (k > 0) check("ready_period", 32'(done_cyc - t_prev), 32'd6);
            t_prev = done_cyc;
        end
        MEM_read = 1'b0;
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
